wishbone_master: RTL and testbench
==================================

WISHBONE_MASTER -- requirements
Module: wishbone_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of BUS-state cycles without ack_i before the master aborts (used only when the timeout macro is defined).
REQ-002 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port req_i  input  1  user request strobe, sampled in IDLE only.
REQ-005 SHALL have port req_we_i  input  1  request direction: 1 = write, 0 = read.
REQ-006 SHALL have port req_addr_i  input  32  request address.
REQ-007 SHALL have port req_data_i  input  32  request write data.
REQ-008 SHALL have port busy_o  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse at the end of a transaction.
REQ-010 SHALL have port err_o  output  1  one-cycle pulse, coincident with done_o, on timeout.
REQ-011 SHALL have port rd_data_o  output  32  data from the last successful read.
REQ-012 SHALL have port addr_o  output  32  Wishbone address.
REQ-013 SHALL have port we_o  output  1  Wishbone write enable.
REQ-014 SHALL have port data_o  output  32  Wishbone write data.
REQ-015 SHALL have port cyc_o  output  1  Wishbone cycle.
REQ-016 SHALL have port stb_o  output  1  Wishbone strobe.
REQ-017 SHALL have port data_i  input  32  Wishbone read data.
REQ-018 SHALL have port ack_i  input  1  Wishbone acknowledge.

Function
REQ-019 SHALL implement three registered states: IDLE, BUS, RELEASE.
REQ-020 In IDLE with req_i=1, SHALL latch req_addr_i, req_we_i and req_data_i into addr_o, we_o and data_o, and SHALL enter BUS on the same edge, so cyc_o=stb_o=1 from the next cycle (1-cycle request-to-bus latency).
REQ-021 In BUS, cyc_o and stb_o SHALL both be high, and addr_o, we_o and data_o SHALL be held stable.
REQ-022 In BUS, on the first edge where ack_i=1, SHALL enter RELEASE and drive cyc_o=stb_o=0.
REQ-023 On that same edge, for a read, SHALL register data_i into rd_data_o; for a write, SHALL leave rd_data_o unchanged.
REQ-024 On that same edge, SHALL register done_o=1 for exactly one cycle.
REQ-025 In RELEASE, SHALL hold cyc_o=stb_o=0 and SHALL return to IDLE on the first edge where ack_i=0; while ack_i stays high, SHALL remain in RELEASE.
REQ-026 SHALL ignore req_i in BUS and RELEASE; the user waits for busy_o=0 and re-asserts the request.
REQ-027 If req_i=1 in the IDLE cycle entered directly from RELEASE, SHALL accept it, giving back-to-back transactions with a minimum spacing of one IDLE cycle.
REQ-028 SHALL ignore ack_i in IDLE.
REQ-029 An ack_i already high when BUS is entered SHALL be treated as a valid acknowledge (single-cycle BUS).
REQ-030 busy_o SHALL be a decode of state: 0 in IDLE, 1 otherwise.

Reset
REQ-031 While rst_i=0, SHALL force IDLE asynchronously, without waiting for clk_i.
REQ-032 While rst_i=0, SHALL drive cyc_o, stb_o, we_o, done_o, err_o and busy_o to 0, and addr_o, data_o and rd_data_o to 32'h0.
REQ-033 Reset asserted mid-transaction SHALL drop cyc_o and stb_o immediately, with no done_o pulse.
REQ-034 After rst_i rises, the first request SHALL be accepted on the first clock edge.

Configuration
REQ-035 With macro WISHBONE_MASTER_TIMEOUT_EN defined, SHALL clear a cycle counter on BUS entry and increment it every BUS cycle with ack_i=0.
REQ-036 With WISHBONE_MASTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES, SHALL enter RELEASE with done_o=1, err_o=1 and rd_data_o unchanged; ack_i on the timeout edge SHALL take precedence (normal completion, err_o=0).
REQ-037 Without WISHBONE_MASTER_TIMEOUT_EN, SHALL contain no counter, SHALL hold err_o constant 0, and BUS SHALL wait indefinitely for ack_i.

Verification
REQ-038 Write: rst_i low->high, req_i=1, we=1, addr=32'h0000_0010, data=32'h0000_002A; slave acks after 2 cycles -> cyc_o/stb_o high 1 cycle after the request, addr_o/data_o stable, done_o one pulse, err_o=0, busy_o low after ack_i falls.
REQ-039 Read: req_i=1, we=0, addr=32'h0000_0010; slave returns 32'hFFFF_FFD5 with ack -> rd_data_o=32'hFFFF_FFD5 in the done_o cycle; a following write leaves rd_data_o unchanged.
REQ-040 Slave holds ack_i high 3 cycles after cyc_o drops -> stays in RELEASE (busy_o=1) for those 3 cycles; a req_i during them is ignored (no cyc_o).
REQ-041 Timeout, macro defined, TIMEOUT_CYCLES=4, slave never acks -> cyc_o high exactly 4 cycles, then done_o=err_o=1 for one cycle, rd_data_o unchanged; without the macro, cyc_o stays high for 1000 cycles.
REQ-042 rst_i pulled low mid-BUS between clock edges -> cyc_o/stb_o/busy_o drop before the next edge, no done_o; after release, a new write completes normally.

Source files
------------

// File: rtl/wishbone_master.sv
// -----------------------------------------------------------------------------
// wishbone_master
//
// Single-transfer Wishbone classic master. A user request strobe (req_i) taken
// in IDLE starts one bus cycle. The master holds cyc/stb until the slave
// acknowledges, then waits in RELEASE for ack_i to drop before it takes the
// next request.
//
// Optional feature macro: WISHBONE_MASTER_TIMEOUT_EN
//   When defined, the master aborts a bus cycle after TIMEOUT_CYCLES cycles
//   without ack_i. It then pulses done_o and err_o together.
//   When undefined, there is no counter, err_o is tied low, and the master
//   waits for ack_i indefinitely.
//
// Ports
//   clk_i       in   1  clock, rising edge
//   rst_i       in   1  asynchronous active-low reset
//   req_i       in   1  user request strobe (sampled in IDLE only)
//   req_we_i    in   1  request direction, 1 = write
//   req_addr_i  in  32  request address
//   req_data_i  in  32  request write data
//   busy_o      out  1  high whenever not IDLE
//   done_o      out  1  one-cycle pulse at end of transaction
//   err_o       out  1  one-cycle pulse with done_o on timeout
//   rd_data_o   out 32  data from last successful read
//   addr_o      out 32  Wishbone address
//   we_o        out  1  Wishbone write enable
//   data_o      out 32  Wishbone write data
//   cyc_o       out  1  Wishbone cycle
//   stb_o       out  1  Wishbone strobe
//   data_i      in  32  Wishbone read data
//   ack_i       in   1  Wishbone acknowledge
// -----------------------------------------------------------------------------
module wishbone_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rd_data_o,
  output logic [31:0] addr_o,
  output logic        we_o,
  output logic [31:0] data_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic [31:0] data_i,
  input  logic        ack_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_we;
  logic [31:0] r_rd_data;
  logic        r_done;

  logic        w_accept;
  logic        w_ack_done;
  logic        w_timeout;

  assign w_accept   = (r_state == IDLE) && req_i;
  assign w_ack_done = (r_state == BUS) && ack_i;

`ifdef WISHBONE_MASTER_TIMEOUT_EN
  // The counter only needs to reach TIMEOUT_CYCLES-1. The abort fires on
  // the edge that would bring it to TIMEOUT_CYCLES, so cyc_o is high for
  // exactly TIMEOUT_CYCLES cycles.
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;
  logic          r_err;

  // A real ack on the same edge wins over the timeout.
  assign w_timeout = (r_state == BUS) && !ack_i &&
                     (r_count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_accept) begin
        r_count <= '0;
      end else if ((r_state == BUS) && !ack_i) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. RELEASE lingers until the slave lets go of ack_i,
  // so a slow slave's stale ack is never seen as acking the next cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          w_next_state = BUS;
        end
      end
      BUS: begin
        if (ack_i || w_timeout) begin
          w_next_state = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_i) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request capture and completion datapath.
  // The address, direction and write data are latched only on acceptance,
  // so they stay stable throughout BUS whatever the user does with req_*.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_rd_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_ack_done || w_timeout;
      if (w_accept) begin
        r_addr <= req_addr_i;
        r_data <= req_data_i;
        r_we   <= req_we_i;
      end
      if (w_ack_done && !r_we) begin
        r_rd_data <= data_i;
      end
    end
  end

  // cyc/stb/busy decode straight from state, so an asynchronous reset
  // drops them immediately.
  assign cyc_o     = (r_state == BUS);
  assign stb_o     = (r_state == BUS);
  assign busy_o    = (r_state != IDLE);
  assign done_o    = r_done;
  assign addr_o    = r_addr;
  assign data_o    = r_data;
  assign we_o      = r_we;
  assign rd_data_o = r_rd_data;

endmodule

// File: tb/tb_wishbone_master.sv
// -----------------------------------------------------------------------------
// tb_wishbone_master
//
// Directed bench for wishbone_master. Each transaction pushes its expected
// completion (read data and error flag) onto a scoreboard queue. The entry
// is popped and compared when done_o is seen.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wishbone_master;

  logic        clk_i      = 1'b0;
  logic        rst_i      = 1'b0;
  logic        req_i      = 1'b0;
  logic        req_we_i   = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rd_data_o;
  logic [31:0] addr_o;
  logic        we_o;
  logic [31:0] data_o;
  logic        cyc_o;
  logic        stb_o;
  logic [31:0] data_i     = '0;
  logic        ack_i      = 1'b0;

  typedef struct {
    logic [31:0] rdData;
    logic        err;
  } exp_t;

  exp_t        sbQueue[$];
  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] lastRead   = '0;

  wishbone_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .req_we_i   (req_we_i),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rd_data_o  (rd_data_o),
    .addr_o     (addr_o),
    .we_o       (we_o),
    .data_o     (data_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .data_i     (data_i),
    .ack_i      (ack_i)
  );

  // 10 ns clock.
  always #5 clk_i = ~clk_i;

  // One comparison: counts it, counts a pass, reports a failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Checks the done cycle and compares it against the oldest scoreboard entry.
  task automatic checkDone(input string tag);
    exp_t e;
    checkOutput({tag, ".done"}, done_o, 1'b1);
    checkOutput({tag, ".cyc"}, cyc_o, 1'b0);
    checkOutput({tag, ".stb"}, stb_o, 1'b0);
    checkOutput({tag, ".busy"}, busy_o, 1'b1);
    checkOutput({tag, ".sbNotEmpty"}, sbQueue.size() != 0, 1'b1);
    if (sbQueue.size() != 0) begin
      e = sbQueue.pop_front();
      checkOutput({tag, ".rdData"}, rd_data_o, e.rdData);
      checkOutput({tag, ".err"}, err_o, e.err);
    end
  endtask

  // Runs one transaction. busCycles is how long cyc_o should stay high.
  // holdCycles is how many extra RELEASE cycles the slave keeps ack_i high.
  // With pokeReq set, req_i is raised during that hold and must be ignored.
  task automatic applyStimulus(input string tag, input logic we,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int busCycles, input logic [31:0] slaveData,
                               input int holdCycles, input logic pokeReq);
    exp_t e;
    e.err    = 1'b0;
    e.rdData = we ? lastRead : slaveData;
    if (!we) lastRead = slaveData;
    sbQueue.push_back(e);

    req_i      = 1'b1;
    req_we_i   = we;
    req_addr_i = addr;
    req_data_i = data;
    data_i     = 32'hDEAD_BEEF;
    // A one-cycle bus phase means the ack is already high when BUS is entered.
    if (busCycles == 1) begin
      ack_i  = 1'b1;
      data_i = slaveData;
    end

    for (int i = 1; i <= busCycles; i++) begin
      @(negedge clk_i);
      req_i      = 1'b0;
      req_addr_i = ~addr;
      req_data_i = ~data;
      req_we_i   = ~we;
      checkOutput({tag, ".cyc"}, cyc_o, 1'b1);
      checkOutput({tag, ".stb"}, stb_o, 1'b1);
      checkOutput({tag, ".busy"}, busy_o, 1'b1);
      checkOutput({tag, ".addr"}, addr_o, addr);
      checkOutput({tag, ".data"}, data_o, data);
      checkOutput({tag, ".we"}, we_o, we);
      checkOutput({tag, ".doneLow"}, done_o, 1'b0);
      if (i == busCycles) begin
        ack_i  = 1'b1;
        data_i = slaveData;
      end
    end

    @(negedge clk_i);
    checkDone(tag);

    for (int i = 0; i < holdCycles; i++) begin
      if (pokeReq) begin
        req_i      = 1'b1;
        req_we_i   = 1'b1;
        req_addr_i = 32'h0000_0BAD;
      end
      @(negedge clk_i);
      checkOutput({tag, ".holdBusy"}, busy_o, 1'b1);
      checkOutput({tag, ".holdCyc"}, cyc_o, 1'b0);
      checkOutput({tag, ".holdDone"}, done_o, 1'b0);
    end

    req_i = 1'b0;
    ack_i = 1'b0;
    @(negedge clk_i);
    checkOutput({tag, ".idleBusy"}, busy_o, 1'b0);
    checkOutput({tag, ".idleCyc"}, cyc_o, 1'b0);
    checkOutput({tag, ".idleDone"}, done_o, 1'b0);
  endtask

  initial begin
    // Reset state, checked while clock edges pass during reset.
    #12;
    checkOutput("rst.cyc", cyc_o, 1'b0);
    checkOutput("rst.stb", stb_o, 1'b0);
    checkOutput("rst.busy", busy_o, 1'b0);
    checkOutput("rst.done", done_o, 1'b0);
    checkOutput("rst.err", err_o, 1'b0);
    checkOutput("rst.we", we_o, 1'b0);
    checkOutput("rst.addr", addr_o, 32'h0);
    checkOutput("rst.data", data_o, 32'h0);
    checkOutput("rst.rdData", rd_data_o, 32'h0);

    @(negedge clk_i);
    rst_i = 1'b1;

    // Write, slave acks after two cycles. The read data presented must not
    // reach rd_data_o.
    applyStimulus("wr1", 1'b1, 32'h0000_0010, 32'h0000_002A, 3, 32'h1234_5678, 0, 1'b0);
    // Back-to-back read with ack already high on BUS entry.
    applyStimulus("rd1", 1'b0, 32'h0000_0010, 32'h0, 1, 32'hFFFF_FFD5, 0, 1'b0);
    // Write while the slave keeps ack_i high 3 extra cycles; a req is ignored.
    applyStimulus("wr2", 1'b1, 32'h0000_0020, 32'h0000_0055, 2, 32'hAAAA_AAAA, 3, 1'b1);
    @(negedge clk_i);
    checkOutput("wr2.pokeIgnored", cyc_o, 1'b0);
    applyStimulus("rd2", 1'b0, 32'h0000_0030, 32'h0, 2, 32'h0BAD_F00D, 0, 1'b0);

`ifdef WISHBONE_MASTER_TIMEOUT_EN
    // Slave never acks: cyc_o for exactly 4 cycles, then done with err.
    begin
      exp_t e;
      e.rdData = lastRead;
      e.err    = 1'b1;
      sbQueue.push_back(e);
      req_i      = 1'b1;
      req_we_i   = 1'b0;
      req_addr_i = 32'h0000_0040;
      data_i     = 32'h5555_5555;
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk_i);
        req_i = 1'b0;
        checkOutput("tmo.cyc", cyc_o, 1'b1);
      end
      @(negedge clk_i);
      checkDone("tmo");
      @(negedge clk_i);
      checkOutput("tmo.idleBusy", busy_o, 1'b0);
      checkOutput("tmo.errPulse", err_o, 1'b0);
    end
`else
    // Without a timeout the master waits as long as the slave stays silent.
    begin
      exp_t e;
      logic allHigh;
      allHigh = 1'b1;
      e.rdData = 32'h7777_0001;
      e.err    = 1'b0;
      lastRead = 32'h7777_0001;
      sbQueue.push_back(e);
      req_i      = 1'b1;
      req_we_i   = 1'b0;
      req_addr_i = 32'h0000_0040;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk_i);
        req_i = 1'b0;
        if (cyc_o !== 1'b1 || stb_o !== 1'b1) allHigh = 1'b0;
      end
      checkOutput("noTmo.cycHeld", allHigh, 1'b1);
      checkOutput("noTmo.err", err_o, 1'b0);
      ack_i  = 1'b1;
      data_i = 32'h7777_0001;
      @(negedge clk_i);
      checkDone("noTmo");
      ack_i = 1'b0;
      @(negedge clk_i);
      checkOutput("noTmo.idleBusy", busy_o, 1'b0);
    end
`endif

    // Reset pulled low mid-BUS, between clock edges.
    req_i      = 1'b1;
    req_we_i   = 1'b1;
    req_addr_i = 32'h0000_0050;
    req_data_i = 32'h0000_00EE;
    @(negedge clk_i);
    req_i = 1'b0;
    checkOutput("rstMid.cycBefore", cyc_o, 1'b1);
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("rstMid.cyc", cyc_o, 1'b0);
    checkOutput("rstMid.stb", stb_o, 1'b0);
    checkOutput("rstMid.busy", busy_o, 1'b0);
    checkOutput("rstMid.done", done_o, 1'b0);
    checkOutput("rstMid.rdData", rd_data_o, 32'h0);
    lastRead = 32'h0;
    @(negedge clk_i);
    checkOutput("rstMid.doneHeld", done_o, 1'b0);
    rst_i = 1'b1;

    // First request after reset release is accepted on the first edge.
    applyStimulus("wr3", 1'b1, 32'h0000_0060, 32'hCAFE_0001, 2, 32'h9999_9999, 0, 1'b0);

    checkOutput("sbDrained", sbQueue.size(), 32'd0);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
